// File: rtl/axi_lite_led_ctrl.sv
// axi_lite_led_ctrl
//
// AXI4-Lite slave holding four 32-bit read/write registers and driving a
// steady or blinking LED pattern from them.
//
//   0x0 CTRL    bit0 EN, bit1 BLINK
//   0x4 PATTERN [LED_WIDTH-1:0] drives the LEDs
//   0x8 PERIOD  blink half-period in clocks (0 means steady)
//   0xC SCRATCH no side effect
//
// Ports:
//   s00_axi_aclk / s00_axi_aresetn     clock, asynchronous active-low reset
//   s00_axi_aw* / s00_axi_w* / s00_axi_b*  write address, data, response channels
//   s00_axi_ar* / s00_axi_r*           read address and data channels
//   led                                registered LED drive, active-high
module axi_lite_led_ctrl #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
    parameter int unsigned LED_WIDTH          = 8
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic [LED_WIDTH-1:0]              led
);

    localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
    localparam int unsigned NumBytes = C_S_AXI_DATA_WIDTH / 8;

    // Channel state
    logic          r_awready;
    logic          r_bvalid;
    logic          r_arready;
    logic          r_rvalid;
    logic [DW-1:0] r_rdata;

    // Register file
    logic [DW-1:0] r_ctrl;
    logic [DW-1:0] r_pattern;
    logic [DW-1:0] r_period;
    logic [DW-1:0] r_scratch;

    // Blink engine and output
    logic [DW-1:0]        r_cnt;
    logic                 r_phase;
    logic [LED_WIDTH-1:0] r_led;

    logic                 w_aw_start;
    logic                 w_wr_hs;
    logic [1:0]           w_wr_sel;
    logic [DW-1:0]        w_wr_old;
    logic [DW-1:0]        w_wr_new;
    logic                 w_ar_start;
    logic                 w_rd_hs;
    logic [1:0]           w_rd_sel;
    logic [DW-1:0]        w_rd_val;
    logic                 w_en;
    logic                 w_blink;
    logic                 w_period_nz;
    logic                 w_active;
    logic                 w_cnt_wrap;
    logic                 w_blink_clr;
    logic [LED_WIDTH-1:0] w_led_d;
    logic                 w_unused;

    // Protection bits and byte-offset address bits carry no meaning here.
    assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                        s00_axi_araddr[1:0]};

    // ------------------------------------------------------------------
    // Write channel: awready/wready pulse together once both valids are
    // seen and no response is outstanding; the handshake lands one edge later.
    // ------------------------------------------------------------------
    assign w_aw_start = s00_axi_awvalid && s00_axi_wvalid && !r_awready && !r_bvalid;
    assign w_wr_hs    = r_awready && s00_axi_awvalid && s00_axi_wvalid;
    assign w_wr_sel   = s00_axi_awaddr[3:2];

    always_comb begin
        w_wr_old = '0;
        case (w_wr_sel)
            2'd0:    w_wr_old = r_ctrl;
            2'd1:    w_wr_old = r_pattern;
            2'd2:    w_wr_old = r_period;
            default: w_wr_old = r_scratch;
        endcase
    end

    // Byte-lane merge of the write data into the current register value.
    always_comb begin
        w_wr_new = w_wr_old;
        for (int i = 0; i < NumBytes; i++) begin
            if (s00_axi_wstrb[i]) begin
                w_wr_new[i*8 +: 8] = s00_axi_wdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
        end else begin
            r_awready <= w_aw_start;
            if (w_wr_hs) begin
                r_bvalid <= 1'b1;
            end else if (r_bvalid && s00_axi_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_ctrl    <= '0;
            r_pattern <= '0;
            r_period  <= '0;
            r_scratch <= '0;
        end else if (w_wr_hs) begin
            case (w_wr_sel)
                2'd0:    r_ctrl    <= w_wr_new;
                2'd1:    r_pattern <= w_wr_new;
                2'd2:    r_period  <= w_wr_new;
                default: r_scratch <= w_wr_new;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read channel: rdata is captured from the pre-write register values, so
    // a read handshaking on the same edge as a write returns the old data.
    // ------------------------------------------------------------------
    assign w_ar_start = s00_axi_arvalid && !r_arready && !r_rvalid;
    assign w_rd_hs    = r_arready && s00_axi_arvalid;
    assign w_rd_sel   = s00_axi_araddr[3:2];

    always_comb begin
        w_rd_val = '0;
        case (w_rd_sel)
            2'd0:    w_rd_val = r_ctrl;
            2'd1:    w_rd_val = r_pattern;
            2'd2:    w_rd_val = r_period;
            default: w_rd_val = r_scratch;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_arready <= w_ar_start;
            if (w_rd_hs) begin
                r_rdata  <= w_rd_val;
                r_rvalid <= 1'b1;
            end else if (r_rvalid && s00_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Blink engine: phase toggles every PERIOD clocks while active. A write to
    // CTRL or PERIOD restarts the half-period so the new setting starts clean.
    // ------------------------------------------------------------------
    assign w_en        = r_ctrl[0];
    assign w_blink     = r_ctrl[1];
    assign w_period_nz = |r_period;
    assign w_active    = w_en && w_blink && w_period_nz;
    assign w_cnt_wrap  = (r_cnt == (r_period - 1'b1));
    assign w_blink_clr = w_wr_hs && ((w_wr_sel == 2'd0) || (w_wr_sel == 2'd2));

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_blink_clr || !w_active) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_cnt_wrap) begin
            r_cnt   <= '0;
            r_phase <= !r_phase;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_led_d = '0;
        if (w_en) begin
            if (w_blink && w_period_nz) begin
                w_led_d = r_phase ? r_pattern[LED_WIDTH-1:0] : '0;
            end else begin
                w_led_d = r_pattern[LED_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_led <= '0;
        end else begin
            r_led <= w_led_d;
        end
    end

    assign s00_axi_awready = r_awready;
    assign s00_axi_wready  = r_awready;
    assign s00_axi_bvalid  = r_bvalid;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_arready = r_arready;
    assign s00_axi_rvalid  = r_rvalid;
    assign s00_axi_rdata   = r_rdata;
    assign s00_axi_rresp   = 2'b00;
    assign led             = r_led;

endmodule

// File: tb/tb_axi_lite_led_ctrl.sv
// Bench for axi_lite_led_ctrl: AXI-Lite master tasks, a register model, and a
// read scoreboard (expected data queued when a read is issued, popped on rvalid).
module tb_axi_lite_led_ctrl;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [7:0]  led;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mdl[4];

    always #5 clk = ~clk;

    axi_lite_led_ctrl #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4),
        .LED_WIDTH          (8)
    ) u_dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (aresetn),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .led             (led)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Address/data phase; the model is updated once the handshake edge passes.
    task automatic aw_phase(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
        int n = 0;
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        forever begin
            @(negedge clk);
            if (awready || n > 50) break;
            n++;
        end
        check_eq("aw_wready", {30'b0, awready, wready}, 32'd3);
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) mdl[addr[3:2]][i*8 +: 8] = data[i*8 +: 8];
        end
    endtask

    task automatic b_phase();
        int n = 0;
        bready = 1'b1;
        forever begin
            @(negedge clk);
            if (bvalid || n > 50) break;
            n++;
        end
        check_eq("bvalid", {31'b0, bvalid}, 32'd1);
        check_eq("bresp", {30'b0, bresp}, 32'd0);
        @(posedge clk);
        #1;
        bready = 1'b0;
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        aw_phase(addr, data, strb);
        b_phase();
    endtask

    task automatic axi_read(input logic [3:0] addr);
        int n = 0;
        exp_q.push_back(mdl[addr[3:2]]);
        araddr  = addr;
        arvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (arready || n > 50) break;
            n++;
        end
        check_eq("arready", {31'b0, arready}, 32'd1);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        rready  = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (rvalid || n > 50) break;
            n++;
        end
        check_eq("rvalid", {31'b0, rvalid}, 32'd1);
        if (exp_q.size() > 0) check_eq("rdata", rdata, exp_q.pop_front());
        check_eq("rresp", {30'b0, rresp}, 32'd0);
        @(posedge clk);
        #1;
        rready = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq(tag, {24'b0, awready, wready, arready, bvalid, rvalid, 3'b0}, 32'd0);
        check_eq({tag, "_led"}, {24'b0, led}, 32'd0);
        check_eq({tag, "_rdata"}, rdata, 32'd0);
    endtask

    initial begin
        logic [7:0] exp_led;
        int         n;

        for (int i = 0; i < 4; i++) mdl[i] = '0;
        aresetn = 1'b0;
        awaddr  = '0; awprot = '0; awvalid = 1'b0;
        wdata   = '0; wstrb  = '0; wvalid  = 1'b0;
        bready  = 1'b0;
        araddr  = '0; arprot = '0; arvalid = 1'b0;
        rready  = 1'b0;

        // Reset state
        #23;
        check_idle_outputs("reset");
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 4; a++) axi_read(4'(a * 4));

        // Sequential writes and readback
        for (int a = 0; a < 4; a++) axi_write(4'(a * 4), 32'(a + 1), 4'hF);
        for (int a = 0; a < 4; a++) axi_read(4'(a * 4));

        // Byte strobes
        axi_write(4'h4, 32'h0000_00A5, 4'b0001);
        axi_write(4'h4, 32'hFFFF_FF00, 4'b0010);
        check_eq("strb_model", mdl[1], 32'h0000_FFA5);
        axi_read(4'h4);

        // Blink with PERIOD=3: three clocks on, three off
        axi_write(4'h0, 32'h0, 4'hF);
        axi_write(4'h4, 32'h0F, 4'hF);
        axi_write(4'h8, 32'd3, 4'hF);
        repeat (2) @(negedge clk);
        check_eq("led_off", {24'b0, led}, 32'd0);
        axi_write(4'h0, 32'h3, 4'hF);
        n = 0;
        while (led != 8'h0F && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 12; k++) begin
            exp_led = (((k / 3) % 2) == 0) ? 8'h0F : 8'h00;
            check_eq("led_blink", {24'b0, led}, {24'b0, exp_led});
            @(negedge clk);
        end

        // Blink disabled -> steady pattern
        axi_write(4'h0, 32'h1, 4'hF);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            check_eq("led_steady_en", {24'b0, led}, 32'h0F);
            @(negedge clk);
        end

        // PERIOD=0 with BLINK set -> steady pattern
        axi_write(4'h0, 32'h3, 4'hF);
        axi_write(4'h8, 32'h0, 4'hF);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            check_eq("led_steady_p0", {24'b0, led}, 32'h0F);
            @(negedge clk);
        end

        // Write response back-pressure blocks the next write
        bready = 1'b0;
        aw_phase(4'hC, 32'h1111_1111, 4'hF);
        awaddr  = 4'h4;
        wdata   = 32'h2222_2222;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("bp_ready_low", {30'b0, awready, wready}, 32'd0);
            check_eq("bp_bvalid_held", {31'b0, bvalid}, 32'd1);
        end
        b_phase();
        aw_phase(4'h4, 32'h2222_2222, 4'hF);
        b_phase();
        axi_read(4'hC);
        axi_read(4'h4);

        // Asynchronous reset mid-blink with a read response pending
        axi_write(4'h4, 32'h0F, 4'hF);
        axi_write(4'h8, 32'd2, 4'hF);
        axi_write(4'h0, 32'h3, 4'hF);
        araddr  = 4'hC;
        arvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (arready || n > 50) break;
            n++;
        end
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        @(negedge clk);
        check_eq("pending_rvalid", {31'b0, rvalid}, 32'd1);
        check_eq("pending_rdata", rdata, 32'h1111_1111);
        n = 0;
        while (led != 8'h0F && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("blink_before_rst", {24'b0, led}, 32'h0F);
        #2;
        aresetn = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        for (int i = 0; i < 4; i++) mdl[i] = '0;
        @(negedge clk);
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 4; a++) axi_read(4'(a * 4));
        check_eq("led_after_rst", {24'b0, led}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
